// File: rtl/delay_stage.sv
// Single pipeline register of the delay line: one PRECISION-wide word with an
// asynchronous active-low clear. The top level chains DELAY of these.
module delay_stage #(
  parameter int PRECISION = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PRECISION-1:0] i_data,
  output logic [PRECISION-1:0] o_data
);

  logic [PRECISION-1:0] r_data;

  // Capture the incoming word every edge; reset clears without waiting for clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else begin
      r_data <= i_data;
    end
  end

  // Output straight from the flop so the stage adds no logic after the register
  assign o_data = r_data;

endmodule

// File: rtl/delay_buffer_0d.sv
// Fixed-latency delay line for one scalar data word.
// DELAY = 0 is a wire; DELAY = N >= 1 is a flat chain of N cleared registers,
// so odata in any cycle is the idata sampled N rising edges earlier.
// The chain is kept as individual flops (not RAM/shift primitives) because
// every stage must clear asynchronously when rst_n falls.
module delay_buffer_0d #(
  parameter int PRECISION = 8,
  parameter int DELAY     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PRECISION-1:0] idata,
  output logic [PRECISION-1:0] odata
);

  // Reject parameter values that have no meaning before anything is built
  if (DELAY < 0) begin : g_bad_delay
    $error("delay_buffer_0d: DELAY must be >= 0 (got %0d)", DELAY);
  end
  if (PRECISION < 1) begin : g_bad_precision
    $error("delay_buffer_0d: PRECISION must be >= 1 (got %0d)", PRECISION);
  end

  if (DELAY == 0) begin : g_passthrough
    // No storage at all: reset cannot touch the output, and unknowns on the
    // input reach the output unchanged.
    logic w_unused_rst_n;
    assign w_unused_rst_n = rst_n;

    assign odata = idata;

    // Pass-through must be exact on every clock
    a_passthrough : assert property (@(posedge clk) odata === idata)
      else $error("delay_buffer_0d: pass-through output differs from input");

  end else if (DELAY >= 1) begin : g_pipeline
    // w_chain[0] is the input, w_chain[i+1] is the output of stage i
    logic [PRECISION-1:0] w_chain [0:DELAY];

    assign w_chain[0] = idata;

    for (genvar gi = 0; gi < DELAY; gi++) begin : g_stage
      delay_stage #(
        .PRECISION (PRECISION)
      ) u_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (w_chain[gi]),
        .o_data (w_chain[gi+1])
      );
    end

    // Last stage drives the port directly
    assign odata = w_chain[DELAY];

    // Edges seen since reset release, saturating at DELAY; only once the
    // pipeline has been completely refilled is odata a real delayed input.
    localparam int CW = $clog2(DELAY + 1);
    logic [CW-1:0] r_fill_cnt;

    // Count refill edges; cleared together with the pipeline
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_fill_cnt <= '0;
      end else if (r_fill_cnt != CW'(DELAY)) begin
        r_fill_cnt <= r_fill_cnt + 1'b1;
      end
    end

    // Once full, the output is exactly the input from DELAY edges ago
    a_latency : assert property (
      @(posedge clk) disable iff (!rst_n)
      (r_fill_cnt == CW'(DELAY)) |-> (odata == $past(idata, DELAY))
    ) else $error("delay_buffer_0d: output is not input delayed by %0d", DELAY);

    // While still refilling, only cleared (zero) words may appear
    a_refill_zero : assert property (
      @(posedge clk) disable iff (!rst_n)
      (r_fill_cnt < CW'(DELAY)) |-> (odata == '0)
    ) else $error("delay_buffer_0d: non-zero output before pipeline refilled");
  end

endmodule

// File: tb/tb_delay_buffer_0d.sv
// Bench for delay_buffer_0d: pass-through, 1- and 3-stage pipelines driven
// from a vector table, a mid-stream asynchronous reset sequence, and random
// 1-bit / 32-bit streams through a 4-stage line checked by a scoreboard.
module tb_delay_buffer_0d;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rst_rn;
  logic [7:0]  idata8;
  logic [7:0]  o0, o1, o3;
  logic [0:0]  idata_p1,  o_p1;
  logic [31:0] idata_p32, o_p32;

  int tests = 0;
  int fails = 0;

  delay_buffer_0d #(.PRECISION(8), .DELAY(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .idata(idata8), .odata(o0));
  delay_buffer_0d #(.PRECISION(8), .DELAY(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .idata(idata8), .odata(o1));
  delay_buffer_0d #(.PRECISION(8), .DELAY(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .idata(idata8), .odata(o3));
  delay_buffer_0d #(.PRECISION(1), .DELAY(4)) u_p1 (
    .clk(clk), .rst_n(rst_rn), .idata(idata_p1), .odata(o_p1));
  delay_buffer_0d #(.PRECISION(32), .DELAY(4)) u_p32 (
    .clk(clk), .rst_n(rst_rn), .idata(idata_p32), .odata(o_p32));

  typedef struct {
    logic [7:0] din;   // word driven before the edge
    logic [7:0] exp1;  // DELAY=1 output after that edge
    logic [7:0] exp3;  // DELAY=3 output after that edge
  } vec_t;

  vec_t tbl [7];

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp3;
  } seq_t;

  seq_t pre_rst  [3];
  seq_t post_rst [4];

  logic [31:0] q32 [$];
  logic [0:0]  q1  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] %s: got %h ok", name, act);
    end
  endtask

  // Hard stop if something stalls the stimulus
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w32, e32;
    logic [0:0]  w1, e1;

    tbl[0] = '{8'd10, 8'd10, 8'd0};
    tbl[1] = '{8'd20, 8'd20, 8'd0};
    tbl[2] = '{8'd30, 8'd30, 8'd10};
    tbl[3] = '{8'd40, 8'd40, 8'd20};
    tbl[4] = '{8'd50, 8'd50, 8'd30};
    tbl[5] = '{8'd50, 8'd50, 8'd40};
    tbl[6] = '{8'd50, 8'd50, 8'd50};

    pre_rst[0]  = '{8'd10, 8'd50};
    pre_rst[1]  = '{8'd20, 8'd50};
    pre_rst[2]  = '{8'd30, 8'd10};
    post_rst[0] = '{8'd60, 8'd0};
    post_rst[1] = '{8'd70, 8'd0};
    post_rst[2] = '{8'd0,  8'd60};
    post_rst[3] = '{8'd0,  8'd70};

    rst_n     = 1'b1;
    rst_rn    = 1'b1;
    idata8    = 8'h00;
    idata_p1  = 1'b0;
    idata_p32 = 32'h0;

    // Enter reset with a falling edge so the async clear actually fires
    #2;
    rst_n  = 1'b0;
    rst_rn = 1'b0;
    idata8 = 8'h5A;
    #1 check("d0_rst_low", 32'(o0), 32'h5A);
    rst_n = 1'b1;
    #1 check("d0_rst_high", 32'(o0), 32'h5A);
    rst_n = 1'b0;
    #1 check("d0_rst_low_again", 32'(o0), 32'h5A);

    // Registered lines stay cleared while clocked in reset
    repeat (2) @(negedge clk);
    check("d1_reset_state", 32'(o1), 32'h0);
    check("d3_reset_state", 32'(o3), 32'h0);

    // Table: release at a negedge, then one word per edge
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      idata8 = tbl[k].din;
      #1 check($sformatf("d0_pass[%0d]", k), 32'(o0), 32'(tbl[k].din));
      @(negedge clk);
      check($sformatf("d1_out[%0d]", k), 32'(o1), 32'(tbl[k].exp1));
      check($sformatf("d3_out[%0d]", k), 32'(o3), 32'(tbl[k].exp3));
    end

    // Mid-stream reset: feed 10,20,30 then clear between edges
    for (int k = 0; k < 3; k++) begin
      idata8 = pre_rst[k].din;
      @(negedge clk);
      check($sformatf("d3_pre_rst[%0d]", k), 32'(o3), 32'(pre_rst[k].exp3));
    end
    #2 rst_n = 1'b0;
    #1 check("d3_async_clear", 32'(o3), 32'h0);
    check("d1_async_clear", 32'(o1), 32'h0);
    check("d0_unaffected", 32'(o0), 32'd30);
    @(negedge clk);
    check("d3_held_in_reset", 32'(o3), 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idata8 = post_rst[k].din;
      @(negedge clk);
      check($sformatf("d3_post_rst[%0d]", k), 32'(o3), 32'(post_rst[k].exp3));
    end

    // Random streams through DELAY=4; cleared pipeline supplies three zeros
    // before the first sampled word reaches the output
    rst_rn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      q32.push_back(32'h0);
      q1.push_back(1'b0);
    end
    for (int i = 0; i < 100; i++) begin
      w32 = $urandom;
      w1  = 1'($urandom_range(0, 1));
      if (i == 10 || i == 50) begin
        w32 = 32'h0;
        w1  = 1'b0;
      end else if (i == 11 || i == 51) begin
        w32 = 32'hFFFF_FFFF;
        w1  = 1'b1;
      end
      idata_p32 = w32;
      idata_p1  = w1;
      q32.push_back(w32);
      q1.push_back(w1);
      @(negedge clk);
      e32 = q32.pop_front();
      e1  = q1.pop_front();
      check($sformatf("p32_stream[%0d]", i), o_p32, e32);
      check($sformatf("p1_stream[%0d]", i), 32'(o_p1), 32'(e1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
